// File: rtl/clk_div_period_meter_pkg.sv
// clk_div_period_meter_pkg: shared state type and counter limit for the period meter
package clk_div_period_meter_pkg;

    typedef enum logic [1:0] {IDLE, ARM, MEAS} meter_state_t;

    function automatic int unsigned cnt_max(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/div_edge_detect.sv
// div_edge_detect: optional synchroniser plus rising-edge detect on the divided clock
module div_edge_detect
    import clk_div_period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic div_in,
    output logic div_s,
    output logic rise
);
    logic div_q;
    if (SYNC_STAGES == 0) begin : g_direct
        assign div_s = div_in;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sr;
        // shift div_in through the synchroniser chain
        always_ff @(posedge clk or posedge rst)
            if (rst) sr <= '0;
            else begin
                sr[0] <= div_in;
                for (int i = 1; i < SYNC_STAGES; i++) sr[i] <= sr[i-1];
            end
        assign div_s = sr[SYNC_STAGES-1];
    end
    // one-cycle history of the sampled waveform for edge detection
    always_ff @(posedge clk or posedge rst)
        if (rst) div_q <= 1'b0;
        else div_q <= div_s;
    assign rise = div_s & ~div_q;
endmodule

// File: rtl/clk_div_period_meter.sv
// clk_div_period_meter: measures period/high/low time of a divided clock and checks it against the divisor
module clk_div_period_meter
    import clk_div_period_meter_pkg::*;
#(
    parameter int N_W         = 8,
    parameter int CNT_W       = 16,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             meas_en,
    input  logic             div_in,
    input  logic [N_W-1:0]   exp_n,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic             meas_valid,
    output logic             mismatch,
    output logic             overflow,
    output logic             lock
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int XW = (N_W > CNT_W) ? N_W : CNT_W;
    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);

    meter_state_t     state;
    logic [CNT_W-1:0] cnt, hi;
    logic [N_W-1:0]   exp_q;
    logic [MW-1:0]    match, base, match_nxt;
    logic             div_s, rise, chg, exp_ok, hit, ovf;

    div_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
        .clk    (clk),
        .rst    (rst),
        .div_in (div_in),
        .div_s  (div_s),
        .rise   (rise)
    );

    assign chg       = exp_q != exp_n;
    assign exp_ok    = exp_n > N_W'(1);
    assign hit       = XW'(cnt) == XW'(exp_n);
    assign ovf       = cnt == MAX;
    assign base      = chg ? '0 : match;
    assign match_nxt = (!exp_ok || !hit) ? '0 : (base == LOCK_M) ? base : base + 1'b1;

    // arm on the first edge, then measure every full period until disabled or timed out
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hi         <= '0;
            exp_q      <= '0;
            match      <= '0;
            period     <= '0;
            high_time  <= '0;
            low_time   <= '0;
            meas_valid <= 1'b0;
            mismatch   <= 1'b0;
            overflow   <= 1'b0;
            lock       <= 1'b0;
        end else begin
            exp_q      <= exp_n;
            meas_valid <= 1'b0;
            mismatch   <= 1'b0;
            overflow   <= 1'b0;
            match      <= base;
            lock       <= base == LOCK_M;
            if (!meas_en) begin
                state <= IDLE;
                match <= '0;
                lock  <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= ARM;
                    ARM: if (rise) begin
                        state <= MEAS;
                        cnt   <= CNT_W'(1);
                        hi    <= CNT_W'(1);
                    end
                    MEAS: if (ovf) begin
                        state    <= ARM;
                        overflow <= 1'b1;
                        match    <= '0;
                        lock     <= 1'b0;
                    end else if (rise) begin
                        period     <= cnt;
                        high_time  <= hi;
                        low_time   <= cnt - hi;
                        meas_valid <= 1'b1;
                        mismatch   <= exp_ok && !hit;
                        match      <= match_nxt;
                        lock       <= match_nxt == LOCK_M;
                        cnt        <= CNT_W'(1);
                        hi         <= CNT_W'(1);
                    end else begin
                        cnt <= ovf ? MAX : cnt + 1'b1;
                        hi  <= (hi == MAX) ? MAX : hi + CNT_W'(div_s);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
endmodule

// File: tb/tb_clk_div_period_meter.sv
// tb_clk_div_period_meter: randomized self-check of the period meter against an array-based reference
module tb_clk_div_period_meter;
    localparam int N_W = 8, CNT_W = 6, LOCK_CNT = 4, SS = 1;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic clk = 1'b0, rst = 1'b1, meas_en = 1'b0, div_in = 1'b0;
    logic [N_W-1:0] exp_n = '0;
    logic [CNT_W-1:0] period, high_time, low_time;
    logic meas_valid, mismatch, overflow, lock;

    int errors = 0, checks = 0;
    int cyc = 0, mode = 0, last = 0, run = 0, prev_n = 0;
    int m_p = 0, m_h = 0, m_l = 0;
    bit m_mv = 0, m_mm = 0, m_ov = 0, dq = 0;
    bit dl[$];
    bit dsh[$];

    clk_div_period_meter #(.N_W(N_W), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst        (rst),
        .meas_en    (meas_en),
        .div_in     (div_in),
        .exp_n      (exp_n),
        .period     (period),
        .high_time  (high_time),
        .low_time   (low_time),
        .meas_valid (meas_valid),
        .mismatch   (mismatch),
        .overflow   (overflow),
        .lock       (lock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, want, cyc);
        end
    endtask

    task automatic check_outs(input string pfx);
        check({pfx, "meas_valid"}, int'(meas_valid), int'(m_mv));
        check({pfx, "mismatch"}, int'(mismatch), int'(m_mm));
        check({pfx, "overflow"}, int'(overflow), int'(m_ov));
        check({pfx, "lock"}, int'(lock), int'(run >= LOCK_CNT));
        check({pfx, "period"}, int'(period), m_p);
        check({pfx, "high_time"}, int'(high_time), m_h);
        check({pfx, "low_time"}, int'(low_time), m_l);
    endtask

    task automatic model_reset();
        mode = 0; run = 0; prev_n = 0; last = 0;
        m_p = 0; m_h = 0; m_l = 0;
        m_mv = 0; m_mm = 0; m_ov = 0; dq = 0;
        dl.delete();
        repeat (SS) dl.push_back(1'b0);
    endtask

    // one clock: drive inputs, let the edge happen, advance the reference, compare
    task automatic tick(input logic en, input logic d);
        bit ds, r;
        int n;
        meas_en = en;
        div_in = d;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
            dsh.push_back(1'b0);
        end else begin
            n = int'(exp_n);
            dl.push_back(d);
            ds = dl.pop_front();
            r = ds & ~dq;
            dq = ds;
            dsh.push_back(ds);
            m_mv = 0; m_mm = 0; m_ov = 0;
            if (n != prev_n) run = 0;
            prev_n = n;
            if (!en) begin
                mode = 0;
                run = 0;
            end else if (mode == 0) begin
                mode = 1;
            end else if (mode == 1) begin
                if (r) begin
                    mode = 2;
                    last = cyc;
                end
            end else if (cyc - last >= MAXC) begin
                m_ov = 1;
                mode = 1;
                run = 0;
            end else if (r) begin
                m_p = cyc - last;
                m_h = 0;
                for (int i = last; i < cyc; i++) m_h += int'(dsh[i]);
                m_l = m_p - m_h;
                m_mv = 1;
                last = cyc;
                if (n < 2) run = 0;
                else if (m_p == n) run = (run < LOCK_CNT) ? run + 1 : run;
                else begin
                    m_mm = 1;
                    run = 0;
                end
            end
        end
        cyc++;
        check_outs("");
    endtask

    task automatic wave(input logic en, input int h, input int l, input int k);
        repeat (k) begin
            repeat (h) tick(en, 1'b1);
            repeat (l) tick(en, 1'b0);
        end
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outs("arst_");
        repeat (3) tick(1'b1, 1'b1);
        repeat (3) tick(1'b1, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        wave(1'b0, 1, 1, 4);
        rst = 1'b0;
        wave(1'b0, 1, 1, 10);
        exp_n = 8'd4;
        wave(1'b1, 2, 2, 8);
        exp_n = 8'd9;
        wave(1'b1, 4, 5, 7);
        wave(1'b1, 4, 4, 6);
        exp_n = 8'd8;
        wave(1'b1, 4, 4, 7);
        exp_n = 8'd4;
        wave(1'b1, 2, 2, 8);
        repeat (80) tick(1'b1, 1'b0);
        wave(1'b1, 2, 2, 3);
        wave(1'b1, 2, 2, 6);
        tick(1'b1, 1'b1);
        async_reset();
        wave(1'b1, 2, 2, 6);
        for (int s = 0; s < 40; s++) begin
            int h, l, k;
            h = $urandom_range(1, 6);
            l = $urandom_range(1, 6);
            k = $urandom_range(0, 3);
            exp_n = N_W'((k == 0 || k == 3) ? h + l : (k == 1) ? h + l + 1 : $urandom_range(0, 1));
            wave($urandom_range(0, 7) != 0, h, l, $urandom_range(2, 7));
            if ($urandom_range(0, 4) == 0) repeat (3) tick(1'b0, 1'b0);
        end
        exp_n = 8'd5;
        repeat (60) tick(1'b1, 1'($urandom_range(0, 1)));
        async_reset();
        wave(1'b1, 3, 2, 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clk_div_period_meter.md
Name: clk_div_period_meter

Overview:
- Sits directly downstream of the programmable divide-by-N clock divider, on the same clk domain.
- Consumes the divider's output waveform as a sampled signal and measures its period, high time and low time in clk cycles.
- Compares the measured period against the programmed divisor and reports per-period measurements, a lock indication, mismatch pulses and timeout/overflow.
- Used for self-check of divider settings and for the divider testbench scoreboard.

Parameters:
- N_W, 8, width of the expected divisor input.
- CNT_W, 16, width of the period, high and low counters and outputs.
- LOCK_CNT, 4, consecutive matching periods required to assert lock (>=1).
- SYNC_STAGES, 0, extra input flops on div_in (0..2); use 2 when div_in is asynchronous.

Ports:
- clk, input, 1, reference clock (the divider's input clock).
- rst, input, 1, reset; asynchronous, active-high.
- meas_en, input, 1, enables measurement; 0 forces IDLE.
- div_in, input, 1, divided clock under test (the divider's clkOut).
- exp_n, input, N_W, programmed divisor; expected period in clk cycles.
- period, output, CNT_W, last measured period.
- high_time, output, CNT_W, clk cycles div_in was high in the last period.
- low_time, output, CNT_W, period minus high_time.
- meas_valid, output, 1, one-cycle pulse when period, high_time and low_time update.
- mismatch, output, 1, one-cycle pulse coincident with meas_valid when period != exp_n (exp_n >= 2 only).
- overflow, output, 1, one-cycle pulse when no rising edge arrives within 2^CNT_W-1 cycles.
- lock, output, 1, level; LOCK_CNT consecutive matching periods observed.

Behaviour:
- Reset (async assert, sync release): all outputs 0, counters 0, state IDLE, edge register 0.
- Edge detect:
  - div_s = div_in after SYNC_STAGES flops; div_q = div_s delayed one cycle.
  - rise = div_s & ~div_q.
- State machine:
  - IDLE -> ARM when meas_en = 1.
  - ARM -> MEAS on the first rise; counters start and no meas_valid is produced.
  - MEAS -> ARM on overflow.
  - Any state -> IDLE the cycle meas_en = 0; this also clears lock and the match counter.
- Counters in ARM (on rise) and in MEAS:
  - On a rise cycle: cnt <= 1, hi <= 1.
  - On other cycles: cnt <= cnt+1, hi <= hi+div_s.
  - Both saturate at 2^CNT_W-1.
- Measurement on a rise in MEAS (outputs registered, valid the next cycle):
  - period <= cnt, high_time <= hi, low_time <= cnt-hi.
  - meas_valid pulses for one cycle.
  - Latency from the div_in rising sample to meas_valid is SYNC_STAGES+1 clk cycles.
- Compare:
  - If exp_n >= 2 and period == exp_n (zero-extended), increment the match counter, saturating at LOCK_CNT; lock = 1 once it reaches LOCK_CNT.
  - If exp_n >= 2 and period != exp_n, mismatch pulses, the match counter clears and lock falls in the same cycle as meas_valid.
  - If exp_n < 2: no mismatch, lock held 0. Divide-by-1 cannot be sampled.
- exp_n change: an internally registered copy is compared every cycle. Any change clears lock and the match counter; the next full period is compared against the new value.
- Overflow: cnt reaching 2^CNT_W-1 in MEAS pulses overflow, clears lock and the match counter, and returns to ARM. meas_valid does not pulse and period is unchanged.
- Simultaneous events:
  - meas_en falling on a rise cycle: IDLE wins and no measurement is produced.
  - A rise on the overflow cycle: overflow wins.
- Reset mid-measurement: everything returns to reset values immediately. After release, the block needs meas_en plus one full arming period before the first meas_valid.

Decomposition:
- Shared package holds meter state enum (IDLE, ARM, MEAS) and a saturating-count max constant function of CNT_W.
- One sub-module: div_edge_detect (SYNC_STAGES flops plus div_q register, outputs div_s and rise).

Test Plan:
- Reset check: rst = 1 with div_in toggling → all outputs 0. Release with meas_en = 0 → meas_valid never pulses.
- Even divisor, locking: meas_en = 1, exp_n = 4, div_in 2 high/2 low.
  - First meas_valid reports period = 4, high_time = 2, low_time = 2.
  - lock rises at the 4th meas_valid.
  - mismatch stays 0.
- Odd divisor: exp_n = 9, div_in 4 high/5 low → period = 9, high_time = 4, low_time = 5, lock after 4 periods.
- Wrong divisor: exp_n = 9, div_in period 8 (4/4) → every meas_valid has mismatch = 1 and lock stays 0.
  - Then switch exp_n to 8 → lock after 4 more valids.
- Timeout: CNT_W = 6, locked at exp_n = 4, then div_in held 0.
  - overflow pulses 63 cycles after the last rise and lock drops.
  - The next two rises give one meas_valid.
- Reset mid-measure: assert rst in MEAS while locked → outputs 0 immediately. After release, the first meas_valid comes on the second rise.
